// File: rtl/pdm_dac_nch.sv
// -----------------------------------------------------------------------------
// pdm_dac_nch
//
// N-channel PDM audio DAC. Each channel holds a signed sample and feeds it to a
// sigma-delta modulator. One PDM bit is produced per channel per clock. The
// modulator is either 1st order (a carry-out accumulator) or 2nd order (two
// saturating integrators).
//
// Parameters
//   NCH : number of channels (1..16)
//   DSZ : sample width, signed two's complement
//
// Ports
//   clk    : modulator clock
//   reset  : asynchronous, active-high reset
//   load   : sample strobe; din is captured on this clock edge
//   din    : packed samples, channel k at din[k*DSZ +: DSZ]
//   ena    : per-channel enable
//   ord    : 0 = 1st-order modulator, 1 = 2nd-order modulator (all channels)
//   clr    : clears all ovf flags
//   pdm    : registered PDM bitstreams
//   ovf    : sticky 2nd-order integrator-saturation flags
//
// Handshake: load is a fire-and-forget strobe. There is no ready, so a sample
// is accepted on every edge where load=1. The held value is used from the
// following edge on.
//
// Optional build macro
//   PDM_DAC_NCH_DITHER_EN : adds a shared 16-bit LFSR. It injects a +1 LSB
//                           dither bit per channel.
// -----------------------------------------------------------------------------
module pdm_dac_nch #(
  parameter int NCH = 2,
  parameter int DSZ = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [NCH*DSZ-1:0] din,
  input  logic [NCH-1:0]     ena,
  input  logic               ord,
  input  logic               clr,
  output logic [NCH-1:0]     pdm,
  output logic [NCH-1:0]     ovf
);

  localparam int I1W = DSZ + 2;  // first integrator width
  localparam int I2W = DSZ + 4;  // second integrator width
  localparam int WW  = DSZ + 6;  // working width: holds every unclamped sum

  localparam logic signed [WW-1:0] I1_MAX = {{(WW-I1W+1){1'b0}}, {(I1W-1){1'b1}}};
  localparam logic signed [WW-1:0] I1_MIN = {{(WW-I1W+1){1'b1}}, {(I1W-1){1'b0}}};
  localparam logic signed [WW-1:0] I2_MAX = {{(WW-I2W+1){1'b0}}, {(I2W-1){1'b1}}};
  localparam logic signed [WW-1:0] I2_MIN = {{(WW-I2W+1){1'b1}}, {(I2W-1){1'b0}}};
  localparam logic signed [WW-1:0] FB_POS = {{(WW-DSZ){1'b0}}, 1'b1, {(DSZ-1){1'b0}}};
  localparam logic signed [WW-1:0] FB_NEG = {{(WW-DSZ+1){1'b1}}, {(DSZ-1){1'b0}}};

  logic [DSZ-1:0] hold_q [NCH];
  logic [DSZ-1:0] hold_d [NCH];
  logic [DSZ-1:0] acc_q  [NCH];
  logic [DSZ-1:0] acc_d  [NCH];
  logic [I1W-1:0] i1_q   [NCH];
  logic [I1W-1:0] i1_d   [NCH];
  logic [I2W-1:0] i2_q   [NCH];
  logic [I2W-1:0] i2_d   [NCH];
  logic           ord_q;
  logic [NCH-1:0] pdm_q, pdm_d;
  logic [NCH-1:0] ovf_q, ovf_d;
  logic [NCH-1:0] dith;

  assign pdm = pdm_q;
  assign ovf = ovf_q;

`ifdef PDM_DAC_NCH_DITHER_EN
  // Fibonacci LFSR x^16+x^14+x^13+x^11+1 in right-shift form.
  logic [15:0] lfsr_q, lfsr_d;
  assign lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr_q <= 16'hACE1;
    else       lfsr_q <= lfsr_d;
  end

  // A disabled channel must stay idle, so its dither is gated off.
  for (genvar g = 0; g < NCH; g++) begin : g_dith
    assign dith[g] = lfsr_q[g % 16] & ena[g];
  end
`else
  assign dith = '0;
`endif

  function automatic logic [I1W-1:0] sat_i1(input logic signed [WW-1:0] v);
    if (v > I1_MAX)      return I1_MAX[I1W-1:0];
    else if (v < I1_MIN) return I1_MIN[I1W-1:0];
    else                 return v[I1W-1:0];
  endfunction

  function automatic logic [I2W-1:0] sat_i2(input logic signed [WW-1:0] v);
    if (v > I2_MAX)      return I2_MAX[I2W-1:0];
    else if (v < I2_MIN) return I2_MIN[I2W-1:0];
    else                 return v[I2W-1:0];
  endfunction

  always_comb begin
    logic                 chg;
    logic [DSZ-1:0]       u;
    logic [DSZ:0]         sum1;
    logic signed [WW-1:0] hold_x, i1_x, i2_x, d_x, fb, s1, s2;
    logic [I2W-1:0]       i2n;
    logic                 sat;

    // An order change restarts every modulator from a clean state.
    chg    = (ord != ord_q);
    u      = '0;
    sum1   = '0;
    hold_x = '0;
    i1_x   = '0;
    i2_x   = '0;
    d_x    = '0;
    fb     = '0;
    s1     = '0;
    s2     = '0;
    i2n    = '0;
    sat    = 1'b0;
    hold_d = hold_q;
    acc_d  = acc_q;
    i1_d   = i1_q;
    i2_d   = i2_q;
    pdm_d  = '0;
    ovf_d  = ovf_q;

    for (int k = 0; k < NCH; k++) begin
      // 1st order: offset-binary sample into a DSZ-bit accumulator.
      // The carry out is the bit stream.
      u    = {~hold_q[k][DSZ-1], hold_q[k][DSZ-2:0]};
      sum1 = {1'b0, acc_q[k]} + {1'b0, u} + {{DSZ{1'b0}}, dith[k]};

      // 2nd order: both integrators update from the old i1 and the old pdm bit.
      hold_x = {{(WW-DSZ){hold_q[k][DSZ-1]}}, hold_q[k]};
      i1_x   = {{(WW-I1W){i1_q[k][I1W-1]}}, i1_q[k]};
      i2_x   = {{(WW-I2W){i2_q[k][I2W-1]}}, i2_q[k]};
      d_x    = {{(WW-1){1'b0}}, dith[k]};
      fb     = pdm_q[k] ? FB_POS : FB_NEG;
      s1     = i1_x + hold_x - fb;
      s2     = i2_x + i1_x - fb + d_x;
      i2n    = sat_i2(s2);
      sat    = (s1 > I1_MAX) || (s1 < I1_MIN) || (s2 > I2_MAX) || (s2 < I2_MIN);

      if (load) hold_d[k] = din[k*DSZ +: DSZ];

      if (chg || !ena[k]) begin
        acc_d[k] = '0;
        i1_d[k]  = '0;
        i2_d[k]  = '0;
        pdm_d[k] = 1'b0;
        sat      = 1'b0;
      end else if (!ord_q) begin
        acc_d[k] = sum1[DSZ-1:0];
        pdm_d[k] = sum1[DSZ];
        sat      = 1'b0;
      end else begin
        i1_d[k]  = sat_i1(s1);
        i2_d[k]  = i2n;
        pdm_d[k] = ~i2n[I2W-1];
      end

      // A clamp in the same cycle as clr keeps the flag set.
      ovf_d[k] = sat | (ovf_q[k] & ~clr);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NCH; k++) begin
        hold_q[k] <= '0;
        acc_q[k]  <= '0;
        i1_q[k]   <= '0;
        i2_q[k]   <= '0;
      end
      ord_q <= 1'b0;
      pdm_q <= '0;
      ovf_q <= '0;
    end else begin
      hold_q <= hold_d;
      acc_q  <= acc_d;
      i1_q   <= i1_d;
      i2_q   <= i2_d;
      ord_q  <= ord;
      pdm_q  <= pdm_d;
      ovf_q  <= ovf_d;
    end
  end

endmodule

// File: tb/tb_pdm_dac_nch.sv
// -----------------------------------------------------------------------------
// tb_pdm_dac_nch
//
// Self-checking bench for pdm_dac_nch (NCH=2, DSZ=16). A behavioural model
// predicts pdm/ovf for every edge into an expected queue. Directed scenarios
// add density and flag checks against hand-derived constants. A random phase
// runs at the end.
// -----------------------------------------------------------------------------
module tb_pdm_dac_nch;
  localparam int NCH = 2;
  localparam int DSZ = 16;
  localparam longint HALF  = longint'(1) << (DSZ-1);
  localparam longint FULL  = longint'(1) << DSZ;
  localparam longint I1_HI = (longint'(1) << (DSZ+1)) - 1;
  localparam longint I1_LO = -(longint'(1) << (DSZ+1));
  localparam longint I2_HI = (longint'(1) << (DSZ+3)) - 1;
  localparam longint I2_LO = -(longint'(1) << (DSZ+3));
`ifdef PDM_DAC_NCH_DITHER_EN
  localparam int XTOL = 2;
`else
  localparam int XTOL = 0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic               clk;
  logic               reset;
  logic               load;
  logic [NCH*DSZ-1:0] din;
  logic [NCH-1:0]     ena;
  logic               ord;
  logic               clr;
  logic [NCH-1:0]     pdm;
  logic [NCH-1:0]     ovf;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pdm_dac_nch #(.NCH(NCH), .DSZ(DSZ)) dut (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .din   (din),
    .ena   (ena),
    .ord   (ord),
    .clr   (clr),
    .pdm   (pdm),
    .ovf   (ovf)
  );

  // ---------------- scoreboard ----------------
  int n_tests;
  int n_fail;
  logic [2*NCH-1:0] exp_q[$];

  task automatic check(input string tag, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Collapses an in-band count onto its centre so check() still prints the raw count on a miss.
  function automatic int band(input int v, input int c, input int tol);
    return (v >= c - tol && v <= c + tol) ? c : v;
  endfunction

  // ---------------- reference model ----------------
  longint m_hold [NCH];
  longint m_acc  [NCH];
  longint m_i1   [NCH];
  longint m_i2   [NCH];
  bit     m_pdm  [NCH];
  bit     m_ovf  [NCH];
  bit     m_ord;
`ifdef PDM_DAC_NCH_DITHER_EN
  int     m_lfsr;
`endif

  function automatic longint clamp(input longint v, input longint lo, input longint hi);
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) begin
      m_hold[k] = 0; m_acc[k] = 0; m_i1[k] = 0; m_i2[k] = 0;
      m_pdm[k] = 0; m_ovf[k] = 0;
    end
    m_ord = 0;
`ifdef PDM_DAC_NCH_DITHER_EN
    m_lfsr = 'hACE1;
`endif
    exp_q.delete();
  endtask

  // Applies one clock edge using the inputs currently driven.
  task automatic model_edge();
    logic [NCH-1:0] pv, ov;
    bit     chg, sat;
    longint d, sum, fb, t1, t2;
    chg = (ord != m_ord);
    for (int k = 0; k < NCH; k++) begin
      d = 0;
`ifdef PDM_DAC_NCH_DITHER_EN
      if (ena[k]) d = (m_lfsr >> (k % 16)) & 1;
`endif
      sat = 0;
      if (chg || !ena[k]) begin
        m_acc[k] = 0; m_i1[k] = 0; m_i2[k] = 0; m_pdm[k] = 0;
      end else if (!m_ord) begin
        sum      = m_acc[k] + m_hold[k] + HALF + d;
        m_pdm[k] = (sum >= FULL);
        m_acc[k] = sum % FULL;
      end else begin
        fb       = m_pdm[k] ? HALF : -HALF;
        t1       = m_i1[k] + m_hold[k] - fb;
        t2       = m_i2[k] + m_i1[k] - fb + d;
        sat      = (t1 > I1_HI) || (t1 < I1_LO) || (t2 > I2_HI) || (t2 < I2_LO);
        m_i1[k]  = clamp(t1, I1_LO, I1_HI);
        m_i2[k]  = clamp(t2, I2_LO, I2_HI);
        m_pdm[k] = (m_i2[k] >= 0);
      end
      if (sat) m_ovf[k] = 1;
      else if (clr) m_ovf[k] = 0;
      if (load) m_hold[k] = longint'($signed(din[k*DSZ +: DSZ]));
      pv[k] = m_pdm[k];
      ov[k] = m_ovf[k];
    end
    m_ord = ord;
`ifdef PDM_DAC_NCH_DITHER_EN
    m_lfsr = (m_lfsr >> 1) | ((((m_lfsr >> 0) ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 1) << 15);
`endif
    exp_q.push_back({ov, pv});
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    logic [2*NCH-1:0] e;
    @(posedge clk);
    model_edge();
    #1;
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 1, 0);
    end else begin
      e = exp_q.pop_front();
      check("pdm", pdm, e[NCH-1:0]);
      check("ovf", ovf, e[2*NCH-1:NCH]);
    end
  endtask

  task automatic set_din(input int c0, input int c1);
    din[DSZ-1:0]     = c0[DSZ-1:0];
    din[2*DSZ-1:DSZ] = c1[DSZ-1:0];
  endtask

  task automatic load_din(input int c0, input int c1);
    set_din(c0, c1);
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic run(input int n, output int ones0, output int ones1, output int ovf0);
    ones0 = 0; ones1 = 0; ovf0 = 0;
    for (int i = 0; i < n; i++) begin
      step();
      ones0 += int'(pdm[0]);
      ones1 += int'(pdm[1]);
      ovf0  += int'(ovf[0]);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int o0, o1, v0, seen, drops;
    logic [31:0] rnd;
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b1; load = 1'b0; din = '0; ena = '1; ord = 1'b0; clr = 1'b0;
    model_reset();

    #12;
    check("rst_pdm", pdm, 0);
    check("rst_ovf", ovf, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("rst_seq", pdm[0], i % 2);
    end

    // 1st order: +16384 gives 3/4 density with a period of 4; -32768 gives nothing.
    load_din(16384, -32768);
    run(4096, o0, o1, v0);
    check("o1_3q_ch0", band(o0, 3072, XTOL), 3072);
    check("o1_min_ch1", o1, 0);
    load_din(-32768, -32768);
    run(1024, o0, o1, v0);
    check("o1_min_ch0", o0, 0);

    // 2nd order at -16384: quarter density, no saturation.
    ord = 1'b1;
    load_din(-16384, 0);
    run(64, o0, o1, v0);
    run(4096, o0, o1, v0);
    check("o2_quarter", band(o0, 1024, 4 + XTOL), 1024);
    check("o2_no_ovf", v0, 0);

    // Near full scale: the second integrator saturates and ovf sticks.
    load_din(32767, 0);
    seen = 0; drops = 0;
    for (int i = 0; i < 10000; i++) begin
      step();
      if (ovf[0]) seen = 1;
      else if (seen != 0) drops++;
    end
    check("sat_ovf", ovf[0], 1);
    check("sat_sticky", drops, 0);

    // Asynchronous reset between edges.
    @(posedge clk);
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    check("arst_pdm", pdm, 0);
    check("arst_ovf", ovf, 0);
    ord = 1'b0;
    set_din(0, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("arst_seq", pdm[0], i % 2);
    end

    // clr against saturation, against a disabled channel, and on a quiet channel.
    ord = 1'b1;
    load_din(32767, 0);
    run(200, o0, o1, v0);
    check("sat2_ovf", ovf[0], 1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_vs_sat", ovf[0], 1);
    ena = 2'b10;
    load_din(0, 0);
    step();
    check("dis_keeps_ovf", ovf[0], 1);
    check("dis_pdm", pdm[0], 0);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_ovf", ovf[0], 0);
    ena = 2'b11;
    run(500, o0, o1, v0);
    check("clr_stays", v0, 0);

    // Per-channel enable.
    ord = 1'b0;
    ena = 2'b01;
    load_din(16384, -16384);
    run(4096, o0, o1, v0);
    check("ena_ch1_off", o1, 0);
    check("ena_ch0_3q", band(o0, 3072, XTOL), 3072);
    ena = 2'b11;
    run(4096, o0, o1, v0);
    check("ena_ch1_q", band(o1, 1024, XTOL), 1024);
    check("ena_ch0_3q2", band(o0, 3072, XTOL), 3072);

    // Order change mid-stream: cleared on the change edge, then the 2nd-order loop starts.
    ord = 1'b1;
    step();
    check("chg_pdm", pdm, 0);
    step();
    check("chg_first", pdm, 3);
    run(64, o0, o1, v0);
    run(4096, o0, o1, v0);
    check("chg_ch0_3q", band(o0, 3072, 4 + XTOL), 3072);
    check("chg_ch1_q", band(o1, 1024, 4 + XTOL), 1024);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rnd  = $urandom();
      load = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) din = {16'h7FFF, 16'h8000};
      else din = rnd[NCH*DSZ-1:0];
      if ($urandom_range(0, 15) == 0) ena = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) ord = ~ord;
      clr = ($urandom_range(0, 19) == 0);
      step();
    end
    load = 1'b0;
    clr  = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pdm_dac_nch.md
Name: pdm_dac_nch

Overview:
Parametrised N-channel PDM audio DAC, the next-generation output stage after the DDC in the ADC receive chain. It accepts packed signed samples with a load strobe and holds them per channel. Each sample drives a selectable 1st-order or 2nd-order sigma-delta modulator, producing one PDM bit per channel per clock. It adds per-channel enable, run-time order select and sticky integrator-saturation flags.

Parameters:
NCH, 2, number of channels (1..16)
DSZ, 16, sample width, signed two's complement

Ports:
clk  in  1  modulator clock (ADC clock domain)
reset  in  1  asynchronous, active-high reset
load  in  1  sample strobe; captures din on this clk edge
din  in  NCH*DSZ  packed samples; channel k at bits [k*DSZ +: DSZ]
ena  in  NCH  per-channel enable
ord  in  1  0 = 1st-order modulator, 1 = 2nd-order modulator (all channels)
clr  in  1  clears all ovf flags
pdm  out  NCH  registered PDM bitstreams
ovf  out  NCH  sticky 2nd-order integrator-saturation flag per channel

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, named reset.
- Reset: hold[k]=0, acc/i1/i2=0, ord_q=0, pdm=0, ovf=0, all immediately on assertion.
- Hold register: load=1 at edge n writes hold[k]=din slice. The modulator first uses the new value for the pdm bit registered at edge n+1. Without load, hold keeps its value indefinitely.
- ord_q <= ord every cycle.
  - Cycle where ord != ord_q (order change): all channels clear acc/i1/i2 and pdm <= 0.
  - Normal operation resumes next cycle.
- Disabled channel (ena[k]=0): acc/i1/i2 held at 0, pdm[k] <= 0, ovf[k] unchanged. Other channels are unaffected.
- 1st order (ord_q=0):
  - u = hold ^ (1<<(DSZ-1)), offset binary.
  - {c, acc} <= acc + u, with acc DSZ bits unsigned and c the carry.
  - pdm <= c.
  - Ones density = u/2^DSZ exactly over 2^DSZ cycles.
- 2nd order (ord_q=1):
  - fb = pdm_q ? +2^(DSZ-1) : -2^(DSZ-1).
  - i1 (DSZ+2 bits signed) <= sat(i1 + hold - fb).
  - i2 (DSZ+4 bits signed) <= sat(i2 + i1 - fb). Uses the old i1.
  - pdm <= (i2_next >= 0).
  - sat clamps to the register's max/min.
- ovf[k] sets on any cycle either saturation clamp engages on channel k. It stays set until clr=1.
  - clr and a simultaneous saturation: set wins.
  - The 1st-order path never sets ovf.
- load concurrent with clr or order change: all actions take effect independently on the same edge.
- All outputs registered; no combinational path from inputs to pdm/ovf.

Optional Feature:
Macro PDM_DAC_NCH_DITHER_EN.
- Defined:
  - Shared 16-bit Fibonacci LFSR: x^16+x^14+x^13+x^11+1, seed 16'hACE1, shifts every clk, reset to seed.
  - Channel k adds lfsr[k mod 16] as +1 LSB: to u in 1st order, to the i2 update term in 2nd order.
  - Dither is suppressed when ena[k]=0.
- Undefined: no LFSR logic; the modulator is fully deterministic as specified above.

Test Plan:
- Reset asserted mid-stream, asynchronously between edges -> pdm=0, ovf=0 before the next edge. After release with ord=0 and din=0, the first pdm bits are 0,1,0,1.
- ord=0, ch0 din=+16384 (DSZ=16), load once -> exactly 49152 ones in the next 65536 pdm[0] bits. Same test with din=-32768 -> 0 ones.
- ord=1, ch0 din=-16384 -> 1024±4 ones over 4096 cycles after 64-cycle settle; ovf[0]=0 throughout.
- ord=1, ch0 din=+32767 held 10000 cycles -> ovf[0]=1 and stays set. A clr pulse with din=0 -> ovf[0]=0 next edge and remains 0.
- NCH=2, din={ch1=-16384, ch0=+16384}, ena=2'b01 -> pdm[1] constantly 0 and ch0 density 75%. Setting ena=2'b11 -> ch1 density 25%.
- Toggle ord 0->1 mid-stream -> pdm=0 on the change cycle, integrators zero. 2nd-order output then begins next cycle with the expected density.
